// File: rtl/text_draw_ctrl.sv
// Glyph string renderer: fetches codes, latches 8x8 bitmaps and plots them pixel by pixel.
// Define TEXT_DRAW_BG_EN to plot background pixels; otherwise 0-bits are transparent.
module text_draw_ctrl #(
    parameter int MAX_CHARS = 16,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOR_W   = 3,
    localparam int ADDR_W   = $clog2(MAX_CHARS),
    localparam int CNT_W    = $clog2(MAX_CHARS) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [CNT_W-1:0]   char_count,
    input  logic [X_W-1:0]     base_x,
    input  logic [Y_W-1:0]     base_y,
    input  logic [COLOR_W-1:0] fg_colour,
    input  logic [COLOR_W-1:0] bg_colour,
    output logic [ADDR_W-1:0]  char_addr,
    input  logic [7:0]         char_data,
    output logic [7:0]         glyph_code,
    input  logic [63:0]        glyph_pixels,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] colour,
    output logic               plot,
    input  logic               pix_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, DONE} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   count_r, idx, idx_next, count_clamped;
    logic [X_W-1:0]     bx;
    logic [Y_W-1:0]     by;
    logic [COLOR_W-1:0] fg;
    logic [63:0]        shadow;
    logic [5:0]         p;
    logic [7:0]         glyph_hold;
    logic [2:0]         row, col;
    logic               pix_bit, pix_done, last_pix;

    assign row           = p[5:3];
    assign col           = p[2:0];
    // Bit 7 of each row is the leftmost column, so the column index is inverted.
    assign pix_bit       = shadow[{row, ~col}];
    assign last_pix      = pix_done && (p == 6'd63);
    assign idx_next      = idx + 1'b1;
    assign count_clamped = (char_count > CNT_W'(MAX_CHARS)) ? CNT_W'(MAX_CHARS) : char_count;

`ifdef TEXT_DRAW_BG_EN
    logic [COLOR_W-1:0] bg;
    assign pix_done = (state == DRAW) && pix_ready;
`else
    logic unused_bg;
    assign unused_bg = ^bg_colour;
    assign pix_done  = (state == DRAW) && (pix_ready || !pix_bit);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = (char_count == '0) ? DONE : FETCH;
            FETCH:   next_state = LATCH;
            LATCH:   next_state = DRAW;
            DRAW:    if (last_pix) next_state = (idx_next < count_r) ? FETCH : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        glyph_code = (state == LATCH) ? char_data : glyph_hold;
        plot       = 1'b0;
        x          = '0;
        y          = '0;
        colour     = '0;
        if (state == DRAW) begin
            x = bx + X_W'({idx, 3'b000}) + X_W'(col);
            y = by + Y_W'(row);
`ifdef TEXT_DRAW_BG_EN
            plot   = 1'b1;
            colour = pix_bit ? fg : bg;
`else
            plot   = pix_bit;
            colour = fg;
`endif
        end
    end

    // char_addr is registered on entry to FETCH so the buffer sees it for the whole FETCH cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r    <= '0;
            idx        <= '0;
            bx         <= '0;
            by         <= '0;
            fg         <= '0;
`ifdef TEXT_DRAW_BG_EN
            bg         <= '0;
`endif
            shadow     <= '0;
            p          <= '0;
            glyph_hold <= '0;
            char_addr  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    count_r <= count_clamped;
                    bx      <= base_x;
                    by      <= base_y;
                    fg      <= fg_colour;
`ifdef TEXT_DRAW_BG_EN
                    bg      <= bg_colour;
`endif
                    idx     <= '0;
                    if (char_count != '0) char_addr <= '0;
                end
                LATCH: begin
                    glyph_hold <= char_data;
                    shadow     <= glyph_pixels;
                    p          <= '0;
                end
                DRAW: if (pix_done) begin
                    p <= p + 1'b1;
                    if (p == 6'd63) begin
                        idx <= idx_next;
                        if (idx_next < count_r) char_addr <= idx_next[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_draw_ctrl.sv
// Randomized bench for text_draw_ctrl against a glyph-list model; honours TEXT_DRAW_BG_EN.
module tb_text_draw_ctrl;

    localparam int MAX_CHARS = 16;
    localparam int X_W = 8, Y_W = 7, C_W = 3, ADDR_W = 4, CNT_W = 5;
`ifdef TEXT_DRAW_BG_EN
    localparam bit BG_MODE = 1'b1;
`else
    localparam bit BG_MODE = 1'b0;
`endif

    typedef logic [X_W+Y_W+C_W-1:0] pix_t;

    logic              clk, resetn, start, pix_ready;
    logic [CNT_W-1:0]  char_count;
    logic [X_W-1:0]    base_x, x;
    logic [Y_W-1:0]    base_y, y;
    logic [C_W-1:0]    fg_colour, bg_colour, colour;
    logic [ADDR_W-1:0] char_addr;
    logic [7:0]        char_data, glyph_code;
    logic [63:0]       glyph_pixels;
    logic              plot, busy, done;

    logic [63:0] rom [256];
    logic [7:0]  text_mem [MAX_CHARS];
    pix_t        exp_q [$];
    int          compared = 0;
    int          mismatched = 0;

    text_draw_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .char_count(char_count),
        .base_x(base_x), .base_y(base_y), .fg_colour(fg_colour), .bg_colour(bg_colour),
        .char_addr(char_addr), .char_data(char_data), .glyph_code(glyph_code),
        .glyph_pixels(glyph_pixels), .x(x), .y(y), .colour(colour), .plot(plot),
        .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign glyph_pixels = rom[glyph_code];
    always @(posedge clk) char_data <= text_mem[char_addr];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    // Reference: every glyph is an 8x8 block at base + 8*char, scanned row-major.
    function automatic void buildModel(input int count, input logic [7:0] bx, input logic [6:0] by,
                                       input logic [2:0] fg, input logic [2:0] bg);
        int n;
        logic [63:0] g;
        logic [7:0] xx;
        logic [6:0] yy;
        bit b;
        n = (count > MAX_CHARS) ? MAX_CHARS : count;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            g = rom[text_mem[c]];
            for (int r = 0; r < 8; r++)
                for (int cl = 0; cl < 8; cl++) begin
                    b  = g[8*r + 7 - cl];
                    xx = 8'(int'(bx) + 8*c + cl);
                    yy = 7'(int'(by) + r);
                    if (BG_MODE || b) exp_q.push_back({xx, yy, b ? fg : bg});
                end
        end
    endfunction

    task automatic checkReset();
        checkOutput("rst_plot", plot, 0);
        checkOutput("rst_x", x, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_colour", colour, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_addr", char_addr, 0);
        checkOutput("rst_glyph", glyph_code, 0);
    endtask

    // bp_mode: 0 = ready always, 1 = random ready, 2 = five-cycle stall on plotted pixel 3.
    task automatic applyStimulus(input int count, input logic [7:0] bx, input logic [6:0] by,
                                 input logic [2:0] fg, input logic [2:0] bg, input int bp_mode,
                                 input bit poke_start, input int abort_at);
        int cyc, done_cyc, stalls, acc, total, n, exp_cyc;
        bit held;
        pix_t held_val;
        logic [ADDR_W-1:0] addr_before;
        buildModel(count, bx, by, fg, bg);
        total = exp_q.size();
        n = (count > MAX_CHARS) ? MAX_CHARS : count;
        exp_cyc = (n == 0) ? 1 : n * 66 + 1;
        addr_before = char_addr;
        @(posedge clk); #1;
        start = 1'b1; char_count = CNT_W'(count); base_x = bx; base_y = by;
        fg_colour = fg; bg_colour = bg; pix_ready = 1'b1;
        cyc = 0; done_cyc = 0; stalls = 0; acc = 0; held = 1'b0;
        while (cyc < 5000 && done_cyc == 0) begin
            @(posedge clk); cyc++; #1;
            start = poke_start && (cyc == 20);
            if (bp_mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
            else if (bp_mode == 2 && acc == 3 && plot && stalls < 5) begin
                pix_ready = 1'b0; stalls++;
            end else pix_ready = 1'b1;
            if (abort_at != 0 && cyc == abort_at) begin
                #1 resetn = 1'b0;
                #1 checkReset();
                return;
            end
            @(negedge clk);
            if (held) checkOutput("hold_stable", {plot, x, y, colour}, {1'b1, held_val});
            held = plot && !pix_ready;
            held_val = {x, y, colour};
            checkOutput("busy", busy, 1);
            if (plot && pix_ready) begin
                if (exp_q.size() == 0) checkOutput("extra_plot", acc + 1, total);
                else checkOutput($sformatf("pixel%0d", acc), {x, y, colour}, exp_q.pop_front());
                acc++;
            end
            if (done) done_cyc = cyc;
        end
        if (done_cyc == 0) checkOutput("done_timeout", 0, 1);
        checkOutput("plot_count", acc, total);
        if (bp_mode != 1) checkOutput("done_cycle", done_cyc, exp_cyc + stalls);
        if (count == 0) checkOutput("addr_unchanged", char_addr, addr_before);
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
    endtask

    task automatic randomText();
        for (int i = 0; i < MAX_CHARS; i++) text_mem[i] = 8'($urandom);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; pix_ready = 1'b1; char_count = '0;
        base_x = '0; base_y = '0; fg_colour = '0; bg_colour = '0;
        for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom};
        rom[0] = 64'h0;
        randomText();
        #7 checkReset();
        #5 resetn = 1'b1;

        text_mem[0] = 8'd1;
        applyStimulus(1, 8'd10, 7'd20, 3'd7, 3'd1, 0, 1'b0, 0);
        applyStimulus(1, 8'd10, 7'd20, 3'd7, 3'd1, 2, 1'b0, 0);
        applyStimulus(0, 8'd33, 7'd44, 3'd5, 3'd2, 0, 1'b0, 0);

        text_mem[0] = 8'd0;
        text_mem[1] = 8'd37;
        applyStimulus(2, 8'd40, 7'd50, 3'd6, 3'd3, 0, 1'b0, 0);

        text_mem[0] = 8'd36;
        applyStimulus(1, 8'd250, 7'd125, 3'd4, 3'd0, 0, 1'b1, 0);

        for (int j = 0; j < 6; j++) begin
            randomText();
            applyStimulus($urandom_range(0, 20), 8'($urandom), 7'($urandom),
                          3'($urandom), 3'($urandom), 1, 1'b0, 0);
        end

        randomText();
        applyStimulus(20, 8'($urandom), 7'($urandom), 3'd2, 3'd5, 0, 1'b0, 0);

        applyStimulus(2, 8'd5, 7'd6, 3'd7, 3'd1, 0, 1'b0, 30);
        #3 resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("post_rst_busy", busy, 0);
            checkOutput("post_rst_done", done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
